// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the SD4 MAC packing stage.
// Field layout, exponent limits, class tags and the signed zero/infinity encodings.
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NORM,
        CLS_SUB
    } fp16_class_e;

    localparam fp16_t FP16_POS_ZERO = '{sign: 1'b0, exp: '0,  frac: '0};
    localparam fp16_t FP16_NEG_ZERO = '{sign: 1'b1, exp: '0,  frac: '0};
    localparam fp16_t FP16_POS_INF  = '{sign: 1'b0, exp: '1,  frac: '0};
    localparam fp16_t FP16_NEG_INF  = '{sign: 1'b1, exp: '1,  frac: '0};

endpackage

// File: rtl/fp16_pack_comb.sv
// Combinational classify/shift/pack of a signed biased exponent and an 11-bit
// significand into a binary16 word; subnormals are truncated, never rounded.
module fp16_pack_comb
    import fp16_pkg::*;
#(
    parameter int EXP_W = 7,
    parameter int SIG_W = 11
) (
    input  logic signed [EXP_W-1:0] i_exp,
    input  logic                    i_sign,
    input  logic        [SIG_W-1:0] i_sig,
    output fp16_t                   o_result
);

    // Thresholds are signed so that e.g. 7'b1111101 is read as -3, not 125.
    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(FP16_EXP_MAX);
    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    fp16_class_e            w_class;
    logic [EXP_W:0]         w_shift;
    logic [FP16_FRAC_W-1:0] w_sub_frac;

    // s = 1 - E, one bit wider than E so -64 maps to 65; only meaningful when E <= 0.
    assign w_shift    = (EXP_W+1)'(1) - {i_exp[EXP_W-1], i_exp};
    assign w_sub_frac = FP16_FRAC_W'(i_sig >> w_shift);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_class = CLS_SUB;
        if (i_sig == '0) begin
            w_class = CLS_ZERO;
        end else if (i_exp >= EXP_INF) begin
            w_class = CLS_INF;
        end else if (i_exp >= EXP_ONE) begin
            w_class = CLS_NORM;
        end
    end

    always_comb begin
        o_result = i_sign ? FP16_NEG_ZERO : FP16_POS_ZERO;
        case (w_class)
            CLS_INF: begin
                o_result = i_sign ? FP16_NEG_INF : FP16_POS_INF;
            end
            CLS_NORM: begin
                o_result.exp  = i_exp[FP16_EXP_W-1:0];
                o_result.frac = i_sig[FP16_FRAC_W-1:0];
            end
            CLS_SUB: begin
                o_result.frac = w_sub_frac;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/subnormal_handling.sv
// Final packing stage of the SD4 MAC datapath: binary16 pack plus one
// registered output stage with a valid flag.
module subnormal_handling
    import fp16_pkg::*;
#(
    parameter int EXP_W = 7,
    parameter int SIG_W = 11,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [EXP_W-1:0] exp_final,
    input  logic                    sign,
    input  logic        [SIG_W-1:0] norm_sum,
    output logic        [OUT_W-1:0] out,
    output logic                    out_valid
);

    fp16_t            w_result;
    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    fp16_pack_comb #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_pack (
        .i_exp    (exp_final),
        .i_sign   (sign),
        .i_sig    (norm_sum),
        .o_result (w_result)
    );

    // Output holds its last value on idle cycles; only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_valid <= in_valid;
            if (in_valid) begin
                r_out <= OUT_W'(w_result);
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_subnormal_handling.sv
// Scoreboard bench for subnormal_handling: the driver pushes reference results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_subnormal_handling;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [6:0]  exp_final;
    logic        sign;
    logic [10:0] norm_sum;
    logic [15:0] out;
    logic        out_valid;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];
    logic [15:0] last_out;

    subnormal_handling dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .exp_final (exp_final),
        .sign      (sign),
        .norm_sum  (norm_sum),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model straight from the packing rules, using integer arithmetic.
    function automatic logic [15:0] ref_pack(input int e, input bit s, input int sig);
        int sh;
        int frac;
        if (sig == 0) return {s, 15'h0000};
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e >= 1) return {s, 5'(e), 10'(sig % 1024)};
        sh = 1 - e;
        frac = (sh >= 11) ? 0 : sig / (1 << sh);
        return {s, 5'h00, 10'(frac)};
    endfunction

    task automatic send(input int e, input bit s, input int sig);
        @(negedge clk);
        in_valid  = 1'b1;
        exp_final = 7'(e);
        sign      = s;
        norm_sum  = 11'(sig);
        exp_q.push_back(ref_pack(e, s, sig));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: compares results on valid cycles, checks that out holds on idle cycles.
    always @(negedge clk) begin
        if (rst) begin
            last_out = 16'h0000;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_valid: got out=%h with no expected result queued", out);
            end else begin
                check("result", out, exp_q.pop_front());
            end
            last_out = out;
        end else begin
            check("idle_hold", out, last_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_out  = 16'h0000;
        in_valid  = 1'b0;
        exp_final = '0;
        sign      = 1'b0;
        norm_sum  = '0;
        rst       = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_out", out, 16'h0000);
        check("reset_valid", {15'h0, out_valid}, 16'h0000);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Directed vectors, issued back to back.
        send(-3, 1'b0, 11'b01010101010);
        send(30, 1'b0, 11'b01010101010);
        send(30, 1'b1, 11'b01010101010);
        send(31, 1'b1, 11'h400);
        send(63, 1'b0, 11'h400);
        send(0,  1'b0, 11'h400);
        send(1,  1'b0, 11'h400);
        send(-10, 1'b0, 11'h7FF);
        send(20, 1'b1, 11'h000);
        send(-64, 1'b1, 11'h7FF);
        send(-9, 1'b0, 11'h7FF);
        send(0,  1'b1, 11'h7FF);
        idle(3);

        // Mid-stream reset: out and out_valid must clear without a clock edge.
        send(12, 1'b0, 11'h5A5);
        send(-2, 1'b1, 11'h6F3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_out", out, 16'h0000);
        check("midreset_valid", {15'h0, out_valid}, 16'h0000);
        exp_q.delete();
        in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        #1;
        check("post_reset_idle_valid", {15'h0, out_valid}, 16'h0000);
        check("post_reset_idle_out", out, 16'h0000);

        // Randomized stimulus with occasional gaps.
        for (int i = 0; i < 400; i++) begin
            int  e;
            int  sig;
            bit  s;
            int  pick;
            e    = int'($urandom_range(0, 127)) - 64;
            s    = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      sig = 0;
            else if (pick <= 6) sig = 1024 + int'($urandom_range(0, 1023));
            else                sig = int'($urandom_range(0, 2047));
            if (pick == 9) e = int'($urandom_range(0, 40)) - 10;
            send(e, s, sig);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        idle(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/subnormal_handling.md
Name: subnormal_handling

Overview:
- Final packing stage of the SD4 MAC datapath.
- Takes the signed, biased result exponent, the sign and the normalized 11-bit significand, and produces an IEEE-754 binary16 word.
- Handles overflow to infinity, exact zero, and underflow into subnormals by right-shifting the significand.
- Output is registered: one pipeline stage with a valid flag.

Parameters:
- EXP_W, 7, width of exp_final; two's-complement signed exponent that already includes the FP16 bias of 15.
- SIG_W, 11, width of norm_sum; bit 10 is the hidden bit, bits 9:0 are the fraction.
- OUT_W, 16, packed result width (binary16: 1 sign, 5 exponent, 10 fraction).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, qualifies exp_final, sign and norm_sum this cycle.
- exp_final, input, 7, signed biased exponent (range -64..63).
- sign, input, 1, result sign.
- norm_sum, input, 11, normalized significand {hidden, fraction[9:0]}.
- out, output, 16, packed binary16 result.
- out_valid, output, 1, out holds a new result.

Behaviour:
- Reset: while rst is high, out = 16'h0000 and out_valid = 0, asynchronously. Both are held until the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle. Inputs sampled on a rising clk edge with in_valid = 1 appear on out at that edge, and out_valid = 1 for that cycle.
- Idle cycles: on an edge with in_valid = 0, out_valid goes to 0 and out holds its previous value. There is no backpressure; every valid input is accepted.
- Classification uses the signed value E = exp_final. Priority runs top to bottom; the first matching rule wins:
  1. Zero: norm_sum == 0. out = {sign, 5'b0, 10'b0}, giving signed zero for any E.
  2. Overflow: E >= 31. out = {sign, 5'b11111, 10'b0}, i.e. infinity. Truncation to max-finite is not used.
  3. Normal: 1 <= E <= 30. out = {sign, E[4:0], norm_sum[9:0]}.
     - norm_sum[10] is not checked; upstream guarantees normalization, and the fraction bits pass through as-is.
  4. Subnormal: E <= 0. Compute shift s = 1 - E (range 1..65).
     - t = norm_sum >> s, logical shift with zeros in.
     - out = {sign, 5'b0, t[9:0]}.
     - If s >= 11, t = 0 and the result is signed zero.
- Rounding: none. Bits shifted out are truncated (round toward zero). No sticky or inexact flag.
- Boundary cases:
  - E = 0 gives s = 1, so the hidden bit lands in fraction bit 9.
  - E = -64 gives s = 65, which yields zero.
  - E = 31 and E = 63 both give infinity.
  - E = 30 is the largest normal.
  - Negative E must be compared as signed; unsigned compare is a bug (7'b1111101 is -3, not 125).
- NaN is never generated.
- Reset asserted mid-operation discards any in-flight result; out_valid drops immediately.

Decomposition:
- Shared package `fp16_pkg` holds:
  - FP16_EXP_W = 5, FP16_FRAC_W = 10, FP16_BIAS = 15, FP16_EXP_MAX = 31;
  - a packed struct typedef fp16_t {sign, exp[4:0], frac[9:0]};
  - constants for +/- zero and +/- infinity.
- One combinational sub-module is natural: `fp16_pack_comb` (classify + shift + pack). The top module is that plus the output register and the valid flop.

Test Plan:
- Subnormal: in_valid=1, exp_final=7'b1111101 (-3), sign=0, norm_sum=11'b01010101010 -> after 1 cycle out=16'h002A (shift by 4), out_valid=1.
- Normal: exp_final=7'b0011110 (30), sign=0, norm_sum=11'b01010101010 -> out=16'h7AAA. Same input with sign=1 -> out=16'hFAAA.
- Overflow: exp_final=31, sign=1, norm_sum=11'h400 -> out=16'hFC00. exp_final=63 -> out=16'h7C00 (with sign=0).
- Boundaries:
  - exp_final=0, norm_sum=11'h400, sign=0 -> out=16'h0200.
  - exp_final=1, norm_sum=11'h400 -> out=16'h0400.
  - exp_final=-10, norm_sum=11'h7FF -> out=16'h0000.
  - norm_sum=0, exp_final=20, sign=1 -> out=16'h8000.
- Reset/valid:
  - Assert rst mid-stream -> out=0 and out_valid=0 immediately, without waiting for a clock edge.
  - After release, a cycle with in_valid=0 -> out_valid=0 and out unchanged.
  - Back-to-back valid inputs produce one result per cycle in order.
